uart_mode2_rx: RTL
==================

Name: uart_mode2_rx

Overview:
8051-style serial Mode 2 receiver. It deserialises an 11-bit frame: start bit (0), 8 data bits LSB first, 9th bit (RB8), stop bit (1). It sits opposite the mode-2 transmitter and uses the same CLK_PER_BIT bit timing. It applies the 8051 multiprocessor (SM2) and RI-gating rules before loading the receive buffer.

Parameters:
CLK_PER_BIT, 100, clk cycles per bit; legal range 8..255.
HALF, CLK_PER_BIT/2, derived localparam; the bit-centre offset.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
rxd  in  1  serial line, asynchronous, idle high
ren  in  1  receive enable (REN)
sm2  in  1  multiprocessor mode: when 1, load only if RB8=1
ri_clr  in  1  single-cycle pulse that clears ri
data_out  out  8  receive buffer (SBUF)
rb8  out  1  received 9th bit
ri  out  1  receive-complete flag, sticky until ri_clr
busy  out  1  high while a frame is being received
frame_err  out  1  sticky; set when the sampled stop bit is 0; cleared by ri_clr
overrun  out  1  one-cycle pulse; a valid frame was dropped because ri was still 1

Behaviour:
- Reset (rst=1 on a clk edge): data_out=0, rb8=0, ri=0, busy=0, frame_err=0, overrun=0. FSM goes to IDLE. Counters clear. Synchroniser flops are set to 1.
- rxd passes through a 2-flop synchroniser (rxd_s). A falling edge is detected when rxd_s goes from 1 to 0.
- clk_cnt counts 0..CLK_PER_BIT-1 and wraps. It resets to 0 in the cycle the falling edge is detected.
- Each bit is sampled at clk_cnt = HALF-1, HALF and HALF+1. The bit value is the 2-of-3 majority, resolved at clk_cnt = HALF+1.
- FSM states:
  - IDLE: busy=0. On a falling edge with ren=1, go to START and set busy=1. Edges while ren=0 are ignored.
  - START: resolve the start bit. If the majority is 1 (glitch), return to IDLE with busy=0 and no flag change. If 0, go to DATA with bit_idx=0.
  - DATA: at each resolve point, shift the majority into an internal shift register MSB-side, so the LSB is received first. bit_idx increments. After bit_idx 7 resolves, go to BIT9.
  - BIT9: resolve and hold the 9th bit internally; go to STOP.
  - STOP: resolve the stop bit, then go to LOAD.
  - LOAD (one cycle): apply the load rules below, then go to IDLE with busy=0. A new start edge is accepted in the cycle after LOAD, i.e. mid-stop-bit, as on the 8051.
- Load rules, evaluated in LOAD:
  - Load condition: ri==0 AND (sm2==0 OR 9th bit==1).
  - If the load condition holds: data_out<=shift reg, rb8<=9th bit, ri<=1. frame_err<=1 if the stop bit is 0, otherwise unchanged.
  - If ri==1: nothing loads, and overrun pulses for 1 cycle.
  - If ri==0, sm2==1 and the 9th bit is 0: frame silently discarded. No flags change.
- Latency: ri rises 1 clk after the stop-bit resolve point, which is HALF+2 clocks after the stop-bit start. That is 10*CLK_PER_BIT+HALF+2 clocks after the start edge reaches rxd_s.
- ri_clr clears ri and frame_err next cycle. If ri_clr and a LOAD set occur in the same cycle, the set wins. For the ri==1 check, LOAD sees ri before the clear.
- ren deasserted mid-frame (any state except IDLE): abort to IDLE next cycle, busy=0, no load, no flag change.
- rst mid-frame: identical to power-on reset; the partial frame is lost.
- data_out and rb8 change only in LOAD.

Test Plan:
- CLK_PER_BIT=16, ren=1, sm2=0. Send data 0xA5 with 9th bit 1 and stop 1. Required: ri=1 exactly 10*16+8+2=170 clocks after the rxd_s fall, data_out=0xA5, rb8=1, frame_err=0, busy low in the same cycle ri rises.
- sm2=1. Send 0x3C with 9th bit 0: ri stays 0 and data_out is unchanged. Then send 0x7E with 9th bit 1: data_out=0x7E, rb8=1, ri=1.
- Drive a rxd low pulse of 3 clocks while idle: busy rises, then drops at start resolve (clk_cnt=HALF+1). ri stays 0 and no state is left behind. A following valid frame 0x11 is received correctly.
- Receive 0x55 without clearing ri, then send 0xAA: overrun pulses one cycle, data_out stays 0x55. After ri_clr, resend 0xAA: data_out=0xAA.
- Send 0x0F with stop bit forced 0: data_out=0x0F, ri=1, frame_err=1. Pulse ri_clr: ri=0 and frame_err=0. Pulse ri_clr in the same cycle as a LOAD: ri remains 1.
- Assert rst at the 4th data bit, then send 0xC3 after release: all outputs are 0 after rst, then data_out=0xC3. Repeat with ren dropped mid-frame: no ri, busy=0.

Source files
------------

// File: rtl/uart_mode2_rx.sv
// 8051-style Mode 2 serial receiver: start, 8 data bits LSB first, 9th bit, stop.
// Applies the SM2/RI gating rules before loading the receive buffer.
module uart_mode2_rx #(
  parameter int unsigned CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       ren,
  input  logic       sm2,
  input  logic       ri_clr,
  output logic [7:0] data_out,
  output logic       rb8,
  output logic       ri,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned HALF = CLK_PER_BIT / 2;

  localparam logic [7:0] CNT_LAST = 8'(CLK_PER_BIT - 1);
  localparam logic [7:0] CNT_S0   = 8'(HALF - 1);
  localparam logic [7:0] CNT_S1   = 8'(HALF);
  localparam logic [7:0] CNT_RES  = 8'(HALF + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    BIT9,
    STOP,
    LOAD
  } state_t;

  state_t     state;
  logic       rxd_m;
  logic       rxd_s;
  logic [7:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       bit9;
  logic       stop_bit;
  logic       samp0;
  logic       samp1;

  logic fall;
  logic maj;
  logic resolve;

  // Fall is flagged in the cycle before rxd_s takes the 0, so that cycle is count 0.
  assign fall    = rxd_s & ~rxd_m;
  assign maj     = (samp0 & samp1) | (samp0 & rxd_s) | (samp1 & rxd_s);
  assign resolve = (clk_cnt == CNT_RES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      bit9      <= 1'b0;
      stop_bit  <= 1'b1;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
      data_out  <= '0;
      rb8       <= 1'b0;
      ri        <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rxd_m   <= rxd;
      rxd_s   <= rxd_m;
      overrun <= 1'b0;

      if (ri_clr) begin
        ri        <= 1'b0;
        frame_err <= 1'b0;
      end

      if (clk_cnt == CNT_S0) samp0 <= rxd_s;
      if (clk_cnt == CNT_S1) samp1 <= rxd_s;

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          busy    <= 1'b0;
          if (fall && ren) begin
            state   <= START;
            busy    <= 1'b1;
            clk_cnt <= 8'd1;
          end
        end

        default: begin
          clk_cnt <= (clk_cnt == CNT_LAST) ? '0 : clk_cnt + 8'd1;
          if (!ren) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            case (state)
              START: begin
                if (resolve) begin
                  if (maj) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                  end else begin
                    state   <= DATA;
                    bit_idx <= '0;
                  end
                end
              end

              DATA: begin
                if (resolve) begin
                  shift_reg <= {maj, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= BIT9;
                end
              end

              BIT9: begin
                if (resolve) begin
                  bit9  <= maj;
                  state <= STOP;
                end
              end

              STOP: begin
                if (resolve) begin
                  stop_bit <= maj;
                  state    <= LOAD;
                end
              end

              LOAD: begin
                state <= IDLE;
                busy  <= 1'b0;
                // ri here is the pre-clear value; a set below overrides ri_clr.
                if (ri) begin
                  overrun <= 1'b1;
                end else if (!sm2 || bit9) begin
                  data_out <= shift_reg;
                  rb8      <= bit9;
                  ri       <= 1'b1;
                  if (!stop_bit) frame_err <= 1'b1;
                end
              end

              default: begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
